sal_cfg_apb_requester: RTL and testbench
========================================

Name: sal_cfg_apb_requester

Overview:
APB3 requester (initiator) that drives the controller's configuration APB port from a simple valid/ready command channel. Boot and host sequencers use it to program and read back the DRAM timing registers (tRCD, tRP, tRAS, tRFC, tRTP, tWTP, tRRD, tCCD, tWTR, tRTW). It performs one transfer at a time: SETUP phase, then ACCESS phase, then returns the read data and error status on a response channel. A timeout guards against a completer that never asserts PREADY.

Parameters:
ADDR_WIDTH, 12, APB address width (byte address).
DATA_WIDTH, 32, APB data width.
TIMEOUT_CYCLES, 255, maximum ACCESS-phase wait cycles before abort. 0 disables the timeout. Range 0..65535.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted (combinational: state==IDLE)
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  target address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  out  1  PSLVERR seen, or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pready  in  1  completer ready
prdata  in  DATA_WIDTH  completer read data
pslverr  in  1  completer error
busy  out  1  state!=IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - All registered outputs are 0: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout.
  - Wait counter is 0.
- Reset asserted mid-transfer: the transfer is abandoned immediately. psel and penable drop asynchronously. No response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and response outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_write, req_addr, req_wdata into pwrite, paddr, pwdata. Set psel=1, penable=0. Go to SETUP.
- SETUP (exactly 1 cycle): set penable=1, clear the wait counter, go to ACCESS.
- ACCESS:
  - psel=1 and penable=1. paddr, pwrite and pwdata are held stable.
  - pready=1 is a completion:
    - psel=0, penable=0, rsp_valid=1.
    - rsp_rdata = pwrite ? 0 : prdata.
    - rsp_err = pslverr; rsp_timeout = 0.
    - Go to RESP.
  - pready=0 with TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 is an abort:
    - psel=0, penable=0, rsp_valid=1.
    - rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1.
    - Go to RESP.
  - Otherwise the counter increments. The counter width is 16 bits and saturates.
  - pslverr and prdata are sampled only when pready=1.
- RESP:
  - rsp_valid and all rsp_* outputs are held until rsp_valid&&rsp_ready.
  - On that handshake: rsp_valid=0, go to IDLE.
  - rsp_rdata, rsp_err and rsp_timeout retain their values after the handshake, until the next response.
- Non-IDLE states: req_ready=0. Commands presented there are not accepted and need not stay stable.
- paddr, pwrite and pwdata retain their last values in IDLE and RESP. psel is never high outside SETUP and ACCESS.
- Minimum transfer period is 4 cycles (accept, SETUP, ACCESS with pready=1, RESP with rsp_ready=1). The next command can be accepted in the following IDLE cycle.
- Timeout boundary:
  - With TIMEOUT_CYCLES=N, the abort happens on the Nth ACCESS cycle with pready=0.
  - pready=1 on that same cycle is a normal completion; completion has priority over abort.
- ACCESS cycles never exceed N, so an unresponsive completer cannot hang the sequencer.

Test Plan:
- Write, pready=1 in the first ACCESS cycle: req addr=0x010, wdata=0x0000_0005 -> psel high 2 cycles with paddr=0x010, pwrite=1, pwdata=5. penable high only in the 2nd cycle. rsp_valid in the next cycle with rsp_err=0, rsp_rdata=0.
- Read, pready held low 3 cycles then high, prdata=0x0000_0021 -> ACCESS lasts 4 cycles, paddr stable throughout. rsp_rdata=0x21, rsp_err=0.
- Read with pready=1 and pslverr=1, prdata=0xDEAD_BEEF -> rsp_err=1, rsp_timeout=0, rsp_rdata=0xDEADBEEF.
- TIMEOUT_CYCLES=4, pready stuck at 0 -> exactly 4 ACCESS cycles, then psel=0. Response: rsp_err=1, rsp_timeout=1, rsp_rdata=0. A variant with pready=1 on the 4th cycle completes normally (rsp_timeout=0).
- Backpressure: rsp_ready=0 for 5 cycles, req_valid held high with a second command -> rsp_* stable, req_ready=0, psel=0 throughout. After rsp_ready=1 the second command is accepted next cycle.
- rst_n pulsed low during ACCESS -> psel, penable and rsp_valid go to 0 without waiting for a clock edge. After release, state=IDLE and req_ready=1. No spurious response appears.

Source files
------------

// File: rtl/sal_cfg_apb_requester.sv
// sal_cfg_apb_requester: valid/ready command channel to APB3 requester with ACCESS-phase timeout.
module sal_cfg_apb_requester #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam bit          TO_EN   = TIMEOUT_CYCLES != 0;
  localparam logic [15:0] TO_LAST = 16'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  state_t      state;
  logic [15:0] cnt;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            pwrite  <= req_write;
            paddr   <= req_addr;
            pwdata  <= req_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS:
          // completion wins over abort on the last permitted cycle
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (TO_EN && cnt == TO_LAST) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else if (cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_sal_cfg_apb_requester.sv
// tb_sal_cfg_apb_requester: vector table, random transfers against a transfer-level model, and reset/backpressure sequences.
module tb_sal_cfg_apb_requester;
  localparam int TO = 4;
  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready, pslverr, busy;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  int          n_pass, n_total;
  logic        bp_w;
  logic [11:0] bp_a;
  logic [31:0] bp_d;

  sal_cfg_apb_requester #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    int          waits;
    logic [31:0] rd;
    logic        se;
    int          hold;
    int          exp_acc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Runs one command through the DUT acting as completer; ready arrives after 'waits' stalled ACCESS cycles.
  task automatic xfer(input vec_t v, input bit bp);
    int n;
    logic [31:0] r;
    logic e, t;
    req_valid = 1'b1; req_write = v.w; req_addr = v.a; req_wdata = v.d;
    chk("idle req_ready", req_ready, 1);
    step;
    req_valid = 1'b0;
    chk("setup psel/penable", {psel, penable}, 2'b10);
    chk("setup paddr", paddr, v.a);
    chk("setup pwrite", pwrite, v.w);
    chk("setup pwdata", pwdata, v.d);
    chk("setup req_ready", req_ready, 0);
    step;
    n = 0;
    while (psel && penable && n < 40) begin
      n++;
      if (paddr !== v.a || pwrite !== v.w || pwdata !== v.d) chk("access addr/ctl stable", {paddr, 19'b0, pwrite}, {v.a, 19'b0, v.w});
      pready  = n > v.waits;
      prdata  = pready ? v.rd : $urandom;
      pslverr = pready ? v.se : 1'($urandom);
      step;
    end
    pready = 1'b0; prdata = $urandom; pslverr = 1'b0;
    chk("access cycles", n, v.exp_acc);
    chk("rsp psel", {psel, penable}, 2'b00);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("rsp_timeout", rsp_timeout, v.exp_to);
    r = rsp_rdata; e = rsp_err; t = rsp_timeout;
    for (int i = 0; i < v.hold; i++) begin
      rsp_ready = 1'b0;
      if (bp) begin
        req_valid = 1'b1; req_write = bp_w; req_addr = bp_a; req_wdata = bp_d;
      end
      step;
      chk("hold rsp stable", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata[28:0]}, {1'b1, e, t, r[28:0]});
      chk("hold req_ready/psel", {req_ready, psel, busy}, 3'b001);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("post rsp_valid", rsp_valid, 0);
    chk("post req_ready", req_ready, 1);
    chk("post retained", {rsp_err, rsp_timeout, rsp_rdata[29:0]}, {e, t, r[29:0]});
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    bp_w = 1'b0; bp_a = '0; bp_d = '0;
    tbl[0] = '{1'b1, 12'h010, 32'h5,        0,  32'h0,        1'b0, 0, 1, 32'h0,        1'b0, 1'b0};
    tbl[1] = '{1'b0, 12'h020, 32'h0,        3,  32'h21,       1'b0, 1, 4, 32'h21,       1'b0, 1'b0};
    tbl[2] = '{1'b0, 12'h030, 32'h0,        0,  32'hDEADBEEF, 1'b1, 0, 1, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 12'h040, 32'h0,        99, 32'h12345678, 1'b0, 2, 4, 32'h0,        1'b1, 1'b1};
    tbl[4] = '{1'b1, 12'h050, 32'hABCD,     99, 32'h0,        1'b0, 0, 4, 32'h0,        1'b1, 1'b1};
    tbl[5] = '{1'b1, 12'hFFC, 32'hFFFFFFFF, 2,  32'h55,       1'b1, 1, 3, 32'h0,        1'b1, 1'b0};
    repeat (2) step;
    chk("reset apb", {psel, penable, pwrite, 12'(paddr), pwdata[16:0]}, 32'h0);
    chk("reset rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata[28:0]}, 32'h0);
    chk("reset pwdata", pwdata, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset ready/busy", {req_ready, busy}, 2'b10);
    rst_n = 1'b1;
    step;
    foreach (tbl[i]) xfer(tbl[i], 1'b0);
    // backpressure with a second command waiting on req_valid
    bp_w = 1'b1; bp_a = 12'h070; bp_d = 32'h77;
    v = '{1'b0, 12'h060, 32'h0, 1, 32'h1234, 1'b0, 5, 2, 32'h1234, 1'b0, 1'b0};
    xfer(v, 1'b1);
    chk("bp second cmd waiting", {req_valid, req_ready}, 2'b11);
    v = '{1'b1, 12'h070, 32'h77, 0, 32'h0, 1'b0, 0, 1, 32'h0, 1'b0, 1'b0};
    xfer(v, 1'b0);
    for (int k = 0; k < 40; k++) begin
      v.w = 1'($urandom); v.a = 12'($urandom); v.d = $urandom;
      v.waits = $urandom_range(0, 6); v.rd = $urandom; v.se = 1'($urandom);
      v.hold = $urandom_range(0, 2);
      v.exp_to    = v.waits >= TO;
      v.exp_acc   = v.exp_to ? TO : v.waits + 1;
      v.exp_rdata = (v.exp_to || v.w) ? 32'h0 : v.rd;
      v.exp_err   = v.exp_to || v.se;
      xfer(v, 1'b0);
    end
    // asynchronous reset while stalled in ACCESS
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h0AA; req_wdata = 32'h0;
    step;
    req_valid = 1'b0;
    step;
    chk("pre-reset access", {psel, penable}, 2'b11);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset psel/penable", {psel, penable}, 2'b00);
    chk("async reset rsp_valid", rsp_valid, 0);
    chk("async reset ready/busy", {req_ready, busy}, 2'b10);
    step;
    rst_n = 1'b1;
    pready = 1'b1; prdata = 32'hBAD; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("no spurious rsp", {rsp_valid, psel, penable, busy}, 4'b0000);
    end
    pready = 1'b0; rsp_ready = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
